// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data memory behind a simple req/ready handshake.
//
// A request seen in IDLE captures WE/A/WD/WM, waits WAIT_CYCLES cycles and then
// answers with a one-cycle ready pulse. Reads return the addressed word. Writes
// merge WD into the addressed word under the byte mask at the edge that ends the
// response cycle, so RD during a write's response shows the old word.
//
// Parameters:
//   DEPTH       - number of 32-bit words (power of two, >= 2)
//   WAIT_CYCLES - wait states before each response (0..15)
//
// Ports:
//   clk   - rising-edge clock
//   rst   - asynchronous active-high reset (storage is not cleared)
//   req   - request, sampled only while idle
//   WE    - 1 = write, 0 = read
//   A     - byte address; word index is A[log2(DEPTH)+1:2], upper bits alias
//   WD    - write data
//   WM    - byte write mask, bit i enables WD[8i+7:8i]
//   RD    - read data, valid with ready, held otherwise
//   ready - one-cycle completion pulse
//   busy  - high from capture until the end of the ready cycle
//   err   - misaligned-access flag, valid with ready
//
// Build option:
//   DMEM_ALIGN_CHK_EN - when defined, A[1:0] != 0 raises err with ready and a
//                       misaligned write leaves storage untouched. When not
//                       defined, err is tied low and A[1:0] is ignored.
module dmem_responder #(
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  input  logic [3:0]  WM,
  output logic [31:0] RD,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned IdxW     = $clog2(DEPTH);
  localparam logic [3:0]  WaitLoad = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [31:0]       wd_q, wd_d;
  logic [3:0]        wm_q, wm_d;
  logic [31:0]       rd_q, rd_d;
  logic              misal;

  logic [31:0]       mem_q [DEPTH];

`ifdef DMEM_ALIGN_CHK_EN
  logic [1:0]        alo_q, alo_d;
  logic              unused_addr;

  assign misal       = (alo_q != 2'b00);
  assign unused_addr = ^A[31:IdxW+2];
`else
  logic              unused_addr;

  assign misal       = 1'b0;
  assign unused_addr = ^{A[31:IdxW+2], A[1:0]};
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    idx_d   = idx_q;
    wd_d    = wd_q;
    wm_d    = wm_q;
    rd_d    = rd_q;
`ifdef DMEM_ALIGN_CHK_EN
    alo_d   = alo_q;
`endif

    case (state_q)
      StIdle: begin
        if (req) begin
          we_d    = WE;
          idx_d   = A[IdxW+1:2];
          wd_d    = WD;
          wm_d    = WM;
          cnt_d   = WaitLoad;
`ifdef DMEM_ALIGN_CHK_EN
          alo_d   = A[1:0];
`endif
          state_d = (WaitLoad == 4'd0) ? StResp : StWait;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Latch the word on entry to RESP; for writes this is the pre-write value
    // because the merge happens at the edge that leaves RESP.
    if ((state_d == StResp) && (state_q != StResp)) begin
      rd_d = mem_q[idx_d];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      idx_q   <= '0;
      wd_q    <= 32'd0;
      wm_q    <= 4'd0;
      rd_q    <= 32'd0;
`ifdef DMEM_ALIGN_CHK_EN
      alo_q   <= 2'b00;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      idx_q   <= idx_d;
      wd_q    <= wd_d;
      wm_q    <= wm_d;
      rd_q    <= rd_d;
`ifdef DMEM_ALIGN_CHK_EN
      alo_q   <= alo_d;
`endif
    end
  end

  // Storage has no reset. A reset asserted during RESP drops state_q to IDLE
  // at once, which also cancels the pending write.
  always_ff @(posedge clk) begin
    if ((state_q == StResp) && we_q && !misal) begin
      for (int b = 0; b < 4; b++) begin
        if (wm_q[b]) begin
          mem_q[idx_q][8*b +: 8] <= wd_q[8*b +: 8];
        end
      end
    end
  end

  assign RD    = rd_q;
  assign ready = (state_q == StResp);
  assign busy  = (state_q != StIdle);
  assign err   = (state_q == StResp) && misal;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned Depth = 256;
  localparam int unsigned WaitC = 2;
`ifdef DMEM_ALIGN_CHK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        WE  = 1'b0;
  logic [31:0] A   = 32'd0;
  logic [31:0] WD  = 32'd0;
  logic [3:0]  WM  = 4'd0;
  logic [31:0] RD;
  logic        ready;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;

  // Reference storage: one word per index, updated by the byte-mask rule.
  logic [31:0] mdl [Depth];
  logic [31:0] last_rd;
  logic        last_err;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
    logic [3:0]  wm;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs [15];

  dmem_responder #(
    .DEPTH       (Depth),
    .WAIT_CYCLES (WaitC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .WE    (WE),
    .A     (A),
    .WD    (WD),
    .WM    (WM),
    .RD    (RD),
    .ready (ready),
    .busy  (busy),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic int unsigned idx_of(input logic [31:0] a);
    return (a >> 2) % Depth;
  endfunction

  task automatic junk();
    req = 1'($urandom);
    WE  = 1'($urandom);
    A   = $urandom;
    WD  = $urandom;
    WM  = 4'($urandom);
  endtask

  // One handshake. Junk (including req=1) is driven while busy to show it is
  // ignored. Counting the capture edge as edge 1, ready must be high after
  // edge WaitC+1.
  task automatic txn(input logic we, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] wm, output logic [31:0] rd, output logic e);
    int lat;
    bit seen;
    @(negedge clk);
    req = 1'b1; WE = we; A = a; WD = wd; WM = wm;
    @(posedge clk); #1;
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat <= 40) begin
      if (ready) begin
        seen = 1'b1;
      end else begin
        chk1("busy_wait", busy, 1'b1);
        junk();
        @(posedge clk); #1;
        lat++;
      end
    end
    chk32("latency", 32'(lat), 32'(WaitC + 1));
    rd = RD;
    e  = err;
    chk1("busy_resp", busy, 1'b1);
    junk();
    @(posedge clk); #1;
    chk1("ready_pulse", ready, 1'b0);
    chk1("busy_idle", busy, 1'b0);
    chk32("rd_hold", RD, rd);
    req = 1'b0;
  endtask

  task automatic do_op(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] wm);
    logic [31:0] exp_rd;
    logic        exp_err;
    int unsigned i;
    i       = idx_of(a);
    exp_rd  = mdl[i];
    exp_err = AlignChk && (a[1:0] != 2'b00);
    txn(we, a, wd, wm, last_rd, last_err);
    chk32("model_rd", last_rd, exp_rd);
    chk1("model_err", last_err, exp_err);
    if (we && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (wm[b]) mdl[i][8*b +: 8] = wd[8*b +: 8];
      end
    end
  endtask

  // Back-to-back reads with req held high and A changing every cycle. With
  // period WaitC+2, captures happen at edges 0, P, 2P...; only those
  // addresses are served.
  task automatic b2b();
    logic [31:0] alist [8];
    int          p;
    p = WaitC + 2;
    for (int k = 0; k < 8; k++) alist[k] = $urandom & 32'h0000_0FFC;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      req = 1'b1; WE = 1'b0; A = alist[k]; WD = $urandom; WM = 4'($urandom);
      @(posedge clk); #1;
      chk1("b2b_busy", busy, (k % p) != (p - 1));
      chk1("b2b_ready", ready, (k % p) == WaitC);
      if ((k % p) == WaitC) chk32("b2b_rd", RD, mdl[idx_of(alist[k - WaitC])]);
    end
    @(negedge clk);
    req = 1'b0;
  endtask

  initial begin
    logic [31:0] v;
    bit          seen;

    // Reset state.
    #2;
    chk32("rst_rd", RD, 32'd0);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Storage powers up unknown: give every word a known value.
    for (int i = 0; i < Depth; i++) begin
      v = 32'(i) * 32'h0101_0101 ^ 32'hA5C3_5A3C;
      txn(1'b1, 32'(i) << 2, v, 4'hF, last_rd, last_err);
      mdl[i] = v;
    end

    vecs[0]  = '{1'b1, 32'h010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{1'b0, 32'h010, 32'h0,         4'b1111, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b1, 32'h010, 32'h0000_00AA, 4'b0001, 1'b0, 32'h0, 1'b0};
    vecs[3]  = '{1'b0, 32'h010, 32'h0,         4'b1111, 1'b1, 32'hDEAD_BEAA, 1'b0};
    vecs[4]  = '{1'b1, 32'h400, 32'h1234_5678, 4'b1111, 1'b0, 32'h0, 1'b0};
    vecs[5]  = '{1'b0, 32'h000, 32'h0,         4'b1111, 1'b1, 32'h1234_5678, 1'b0};
    vecs[6]  = '{1'b1, 32'h010, 32'hAABB_CCDD, 4'b0000, 1'b0, 32'h0, 1'b0};
    vecs[7]  = '{1'b0, 32'h010, 32'h0,         4'b0000, 1'b1, 32'hDEAD_BEAA, 1'b0};
    vecs[8]  = '{1'b1, 32'h020, 32'h0000_0000, 4'b1111, 1'b0, 32'h0, 1'b0};
    vecs[9]  = '{1'b1, 32'h022, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0, AlignChk};
    vecs[10] = '{1'b0, 32'h020, 32'h0,         4'b1111, 1'b1,
                 AlignChk ? 32'h0000_0000 : 32'hFFFF_FFFF, 1'b0};
    vecs[11] = '{1'b0, 32'h023, 32'h0,         4'b1111, 1'b1,
                 AlignChk ? 32'h0000_0000 : 32'hFFFF_FFFF, AlignChk};
    vecs[12] = '{1'b1, 32'h3FC, 32'hFFFF_0000, 4'b1111, 1'b0, 32'h0, 1'b0};
    vecs[13] = '{1'b1, 32'h3FC, 32'h0102_0304, 4'b1010, 1'b0, 32'h0, 1'b0};
    vecs[14] = '{1'b0, 32'h3FC, 32'h0,         4'b1111, 1'b1, 32'h01FF_0300, 1'b0};

    for (int n = 0; n < 15; n++) begin
      do_op(vecs[n].we, vecs[n].a, vecs[n].wd, vecs[n].wm);
      if (vecs[n].chk_rd) chk32($sformatf("vec%0d_rd", n), last_rd, vecs[n].exp_rd);
      chk1($sformatf("vec%0d_err", n), last_err, vecs[n].exp_err);
    end

    // Reset during WAIT of a write to 0x20 (currently 0): aborted, no pulse.
    do_op(1'b1, 32'h020, 32'h0, 4'hF);
    @(negedge clk);
    req = 1'b1; WE = 1'b1; A = 32'h020; WD = 32'h5555_AAAA; WM = 4'hF;
    @(posedge clk); #1;
    req = 1'b0;
    chk1("wait_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_ready", ready, 1'b0);
    chk32("abort_rd", RD, 32'd0);
    chk1("abort_err", err, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk1("abort_no_ready", ready, 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 32'h020, 32'h0, 4'hF);
    chk32("abort_word", last_rd, 32'h0000_0000);

    // Reset during RESP of a write to 0x30: the write must not land.
    @(negedge clk);
    req = 1'b1; WE = 1'b1; A = 32'h030; WD = 32'h1357_2468; WM = 4'hF;
    @(posedge clk); #1;
    req  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (ready) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk1("resp_seen", 1'(seen), 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("resp_abort_ready", ready, 1'b0);
    chk32("resp_abort_rd", RD, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_op(1'b0, 32'h030, 32'h0, 4'hF);

    b2b();

    for (int n = 0; n < 150; n++) begin
      do_op(1'($urandom), $urandom & 32'h0000_0FFF, $urandom, 4'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
